// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255-style PPI bus master.
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_INIT
  } ppiState_t;

  localparam logic [1:0] PPI_ADDR_A    = 2'b00;
  localparam logic [1:0] PPI_ADDR_B    = 2'b01;
  localparam logic [1:0] PPI_ADDR_C    = 2'b10;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'b11;

  localparam logic [7:0] PPI_RESET_CW = 8'h9B;

endpackage

// File: rtl/ppi_phase_timer.sv
// 8-bit loadable down-counter shared by every bus phase; done flags a count of zero.
module ppi_phase_timer (
  input  logic       clk,
  input  logic       Reset_low,
  input  logic       load,
  input  logic [7:0] loadVal,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge Reset_low) begin
    if (!Reset_low) begin
      count <= 8'd0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Host valid/ready to 8255 PPI bus cycle sequencer with programmable setup/strobe/hold/recovery.
// Optional start-up control-word write is enabled by defining PPI_BUS_MASTER_INIT_EN.
import ppi_pkg::*;

module ppi_bus_master #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 2,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 1,
  parameter logic [7:0]  INIT_CW      = PPI_RESET_CW
) (
  input  logic       clk,
  input  logic       Reset_low,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       cs_low,
  output logic       RD_low,
  output logic       WR_low,
  output logic       A0,
  output logic       A1,
  inout  wire  [7:0] data_buffer
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RECOV_LD  = (RECOVERY_CYC == 0) ? 8'd0 : 8'(RECOVERY_CYC - 1);

`ifdef PPI_BUS_MASTER_INIT_EN
  localparam ppiState_t RESET_STATE = ST_INIT;
`else
  localparam ppiState_t RESET_STATE = ST_IDLE;
`endif

  ppiState_t  state;
  logic       isWrite;
  logic       silent;
  logic       driveEn;
  logic [7:0] wdataLatch;
  logic [7:0] rdataLatch;
  logic       accept;
  logic       timerLoad;
  logic [7:0] timerVal;
  logic       phaseDone;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;

  // Every phase loads the shared timer on the edge that enters it.
  always_comb begin
    timerLoad = 1'b0;
    timerVal  = SETUP_LD;
    case (state)
      ST_IDLE:   timerLoad = accept;
      ST_INIT:   timerLoad = 1'b1;
      ST_SETUP:  begin timerLoad = phaseDone; timerVal = STROBE_LD; end
      ST_STROBE: begin timerLoad = phaseDone; timerVal = HOLD_LD;   end
      ST_HOLD:   begin timerLoad = phaseDone; timerVal = RECOV_LD;  end
      default:   ;
    endcase
  end

  ppi_phase_timer uTimer (
    .clk       (clk),
    .Reset_low (Reset_low),
    .load      (timerLoad),
    .loadVal   (timerVal),
    .done      (phaseDone)
  );

  always_ff @(posedge clk or negedge Reset_low) begin
    if (!Reset_low) begin
      state     <= RESET_STATE;
      cs_low    <= 1'b1;
      RD_low    <= 1'b1;
      WR_low    <= 1'b1;
      {A1, A0}  <= PPI_ADDR_A;
      driveEn   <= 1'b0;
      isWrite   <= 1'b0;
      silent    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          state    <= ST_SETUP;
          cs_low   <= 1'b0;
          {A1, A0} <= PPI_ADDR_CTRL;
          isWrite  <= 1'b1;
          driveEn  <= 1'b1;
          silent   <= 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            cs_low    <= 1'b0;
            {A1, A0}  <= req_addr;
            isWrite   <= req_write;
            driveEn   <= req_write;
            silent    <= 1'b0;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (phaseDone) begin
            state  <= ST_STROBE;
            WR_low <= !isWrite;
            RD_low <= isWrite;
          end
        end
        ST_STROBE: begin
          if (phaseDone) begin
            state  <= ST_HOLD;
            WR_low <= 1'b1;
            RD_low <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (phaseDone) begin
            cs_low   <= 1'b1;
            {A1, A0} <= PPI_ADDR_A;
            driveEn  <= 1'b0;
            if (!silent) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= isWrite ? 8'h00 : rdataLatch;
            end
            if (RECOVERY_CYC == 0) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end else begin
              state <= ST_RECOVER;
            end
          end
        end
        ST_RECOVER: begin
          if (phaseDone) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Payload registers carry no reset; they are only consumed under control of the FSM.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      wdataLatch <= INIT_CW;
    end else if (accept) begin
      wdataLatch <= req_wdata;
    end
    if ((state == ST_STROBE) && phaseDone && !isWrite) begin
      rdataLatch <= data_buffer;
    end
  end

  assign data_buffer = driveEn ? wdataLatch : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed self-checking bench for ppi_bus_master with a small PPI bus model.
`timescale 1ns/1ps
module tb_ppi_bus_master;
  import ppi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset_low = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_addr  = 2'b00;
  logic [7:0] req_wdata = 8'h00;
  logic [7:0] rdModel   = 8'hA5;
  wire        req_ready, rsp_valid, cs_low, RD_low, WR_low, A0, A1;
  wire  [7:0] rsp_rdata;
  wire  [7:0] data_buffer;

  // PPI model: drives read data while RD_low is low, and a marker value while deselected
  // so that any stray master drive corrupts what the bench observes.
  assign data_buffer = !RD_low ? rdModel : (cs_low ? 8'h3C : 8'bzzzz_zzzz);

  int checks = 0;
  int passes = 0;

  ppi_bus_master dut (
    .clk (clk), .Reset_low (Reset_low),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
    .cs_low (cs_low), .RD_low (RD_low), .WR_low (WR_low),
    .A0 (A0), .A1 (A1), .data_buffer (data_buffer)
  );

  task automatic waitReady(output bit ok);
    int n = 0;
    while (req_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    ok = (req_ready === 1'b1);
  endtask

  task automatic startReq(input logic w, input logic [1:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_low = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b11; req_wdata = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs_low !== 1'b1) $display("FAIL reset cs_low: got %b want 1", cs_low); else passes++;
    checks++; if (RD_low !== 1'b1) $display("FAIL reset RD_low: got %b want 1", RD_low); else passes++;
    checks++; if (WR_low !== 1'b1) $display("FAIL reset WR_low: got %b want 1", WR_low); else passes++;
    checks++; if ({A1, A0} !== 2'b00) $display("FAIL reset addr: got %b want 00", {A1, A0}); else passes++;
    checks++; if (data_buffer !== 8'h3C) $display("FAIL reset bus released: got %h want 3c", data_buffer); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL reset req_ready: got %b want 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== 8'h00) $display("FAIL reset rsp_rdata: got %h want 00", rsp_rdata); else passes++;
    #3 Reset_low = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef PPI_BUS_MASTER_INIT_EN
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++; if (cs_low !== (c <= 4 ? 1'b0 : 1'b1)) $display("FAIL init cs_low c%0d: got %b", c, cs_low); else passes++;
      checks++; if (WR_low !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) $display("FAIL init WR_low c%0d: got %b", c, WR_low); else passes++;
      if (c <= 4) begin
        checks++; if ({A1, A0} !== PPI_ADDR_CTRL) $display("FAIL init addr c%0d: got %b want 11", c, {A1, A0}); else passes++;
        checks++; if (data_buffer !== 8'h9B) $display("FAIL init data c%0d: got %h want 9b", c, data_buffer); else passes++;
      end
      checks++; if (rsp_valid !== 1'b0) $display("FAIL init rsp_valid c%0d: got %b want 0", c, rsp_valid); else passes++;
      checks++; if (req_ready !== (c == 6 ? 1'b1 : 1'b0)) $display("FAIL init req_ready c%0d: got %b", c, req_ready); else passes++;
    end
`else
    checks++; if (req_ready !== 1'b1) $display("FAIL reset release req_ready: got %b want 1", req_ready); else passes++;
    checks++; if (cs_low !== 1'b1) $display("FAIL reset release cs_low: got %b want 1", cs_low); else passes++;
`endif
  endtask

  task automatic test_write();
    bit ok;
    waitReady(ok);
    checks++; if (!ok) $display("FAIL write ready timeout: req_ready=%b want 1", req_ready); else passes++;
    startReq(1'b1, PPI_ADDR_A, 8'h55);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++; if (cs_low !== (c <= 4 ? 1'b0 : 1'b1)) $display("FAIL write cs_low c%0d: got %b", c, cs_low); else passes++;
      checks++; if (WR_low !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) $display("FAIL write WR_low c%0d: got %b", c, WR_low); else passes++;
      checks++; if (RD_low !== 1'b1) $display("FAIL write RD_low c%0d: got %b want 1", c, RD_low); else passes++;
      checks++; if ({A1, A0} !== 2'b00) $display("FAIL write addr c%0d: got %b want 00", c, {A1, A0}); else passes++;
      checks++; if (data_buffer !== (c <= 4 ? 8'h55 : 8'h3C)) $display("FAIL write data c%0d: got %h", c, data_buffer); else passes++;
      checks++; if (rsp_valid !== (c == 5)) $display("FAIL write rsp_valid c%0d: got %b", c, rsp_valid); else passes++;
      checks++; if (req_ready !== (c == 6)) $display("FAIL write req_ready c%0d: got %b", c, req_ready); else passes++;
      if (c == 5) begin
        checks++; if (rsp_rdata !== 8'h00) $display("FAIL write rsp_rdata: got %h want 00", rsp_rdata); else passes++;
      end
    end
  endtask

  task automatic test_read();
    bit ok;
    waitReady(ok);
    checks++; if (!ok) $display("FAIL read ready timeout: req_ready=%b want 1", req_ready); else passes++;
    rdModel = 8'hA5;
    startReq(1'b0, PPI_ADDR_B, 8'hFF);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++; if (cs_low !== (c <= 4 ? 1'b0 : 1'b1)) $display("FAIL read cs_low c%0d: got %b", c, cs_low); else passes++;
      checks++; if (RD_low !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) $display("FAIL read RD_low c%0d: got %b", c, RD_low); else passes++;
      checks++; if (WR_low !== 1'b1) $display("FAIL read WR_low c%0d: got %b want 1", c, WR_low); else passes++;
      checks++; if ({A1, A0} !== (c <= 4 ? 2'b01 : 2'b00)) $display("FAIL read addr c%0d: got %b", c, {A1, A0}); else passes++;
      if (c == 2 || c == 3) begin
        checks++; if (data_buffer !== 8'hA5) $display("FAIL read bus c%0d: got %h want a5", c, data_buffer); else passes++;
      end else if (c >= 5) begin
        checks++; if (data_buffer !== 8'h3C) $display("FAIL read bus idle c%0d: got %h want 3c", c, data_buffer); else passes++;
      end
      checks++; if (rsp_valid !== (c == 5)) $display("FAIL read rsp_valid c%0d: got %b", c, rsp_valid); else passes++;
      checks++; if (req_ready !== (c == 6)) $display("FAIL read req_ready c%0d: got %b", c, req_ready); else passes++;
      if (c == 5) begin
        checks++; if (rsp_rdata !== 8'hA5) $display("FAIL read rsp_rdata: got %h want a5", rsp_rdata); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic       expCs;
    logic [1:0] expAddr;
    logic [7:0] expData;
    waitReady(ok);
    checks++; if (!ok) $display("FAIL b2b ready timeout: req_ready=%b want 1", req_ready); else passes++;
    req_valid = 1'b1; req_write = 1'b1; req_addr = PPI_ADDR_C; req_wdata = 8'h0F;
    @(posedge clk); #1;
    req_addr = PPI_ADDR_CTRL; req_wdata = 8'h80;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      expCs   = !((c >= 1 && c <= 4) || (c >= 7 && c <= 10));
      expAddr = (c <= 4) ? PPI_ADDR_C : ((c >= 7 && c <= 10) ? PPI_ADDR_CTRL : 2'b00);
      expData = (c <= 4) ? 8'h0F : ((c >= 7 && c <= 10) ? 8'h80 : 8'h3C);
      checks++; if (cs_low !== expCs) $display("FAIL b2b cs_low c%0d: got %b want %b", c, cs_low, expCs); else passes++;
      checks++; if ({A1, A0} !== expAddr) $display("FAIL b2b addr c%0d: got %b want %b", c, {A1, A0}, expAddr); else passes++;
      checks++; if (data_buffer !== expData) $display("FAIL b2b data c%0d: got %h want %h", c, data_buffer, expData); else passes++;
      checks++; if (WR_low !== !(c == 2 || c == 3 || c == 8 || c == 9)) $display("FAIL b2b WR_low c%0d: got %b", c, WR_low); else passes++;
      checks++; if (rsp_valid !== (c == 5 || c == 11)) $display("FAIL b2b rsp_valid c%0d: got %b", c, rsp_valid); else passes++;
      checks++; if (req_ready !== (c == 6 || c == 12)) $display("FAIL b2b req_ready c%0d: got %b", c, req_ready); else passes++;
      if (c == 7) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit sawRsp = 1'b0;
    int n = 0;
    waitReady(ok);
    checks++; if (!ok) $display("FAIL midrst ready timeout: req_ready=%b want 1", req_ready); else passes++;
    startReq(1'b1, PPI_ADDR_A, 8'hAA);
    @(posedge clk); #1;
    checks++; if (WR_low !== 1'b0) $display("FAIL midrst strobe active: got %b want 0", WR_low); else passes++;
    #2 Reset_low = 1'b0;
    #1;
    checks++; if (WR_low !== 1'b1) $display("FAIL midrst WR_low: got %b want 1", WR_low); else passes++;
    checks++; if (cs_low !== 1'b1) $display("FAIL midrst cs_low: got %b want 1", cs_low); else passes++;
    checks++; if (data_buffer !== 8'h3C) $display("FAIL midrst bus released: got %h want 3c", data_buffer); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL midrst req_ready: got %b want 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL midrst rsp_valid: got %b want 0", rsp_valid); else passes++;
    #1 Reset_low = 1'b1;
    while (req_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
      if (rsp_valid === 1'b1) sawRsp = 1'b1;
    end
    checks++; if (req_ready !== 1'b1) $display("FAIL midrst recover: req_ready=%b want 1", req_ready); else passes++;
    checks++; if (sawRsp) $display("FAIL midrst dropped access: rsp_valid seen=1 want 0"); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
